// File: rtl/avmm_dma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : avmm_dma_pkg
// Description : Shared types and helpers for the Avalon-MM burst write path.
//               Holds the writer FSM state type, the default word geometry
//               and width helpers used to size ports and counters.
// Revision    : 1.0 - initial release
// ============================================================================
package avmm_dma_pkg;

    // Writer control states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Default word geometry (32-bit data path)
    localparam int DEF_DW         = 32;
    localparam int BYTES_PER_WORD = DEF_DW / 8;
    localparam int WORD_SHIFT     = $clog2(BYTES_PER_WORD);

    // Byte-to-word address shift for a given data width
    function automatic int f_word_shift(input int dw);
        return $clog2(dw / 8);
    endfunction

    // Width needed to hold a burstcount value of 1..max_burst
    function automatic int f_bc_width(input int max_burst);
        return $clog2(max_burst) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/avmm_burst_sizer.sv
`default_nettype none
// ============================================================================
// Module      : avmm_burst_sizer
// Description : Combinational burst length calculator. Returns the smaller of
//               the remaining word count and the distance (in words) to the
//               next MAX_BURST-aligned boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module avmm_burst_sizer
    import avmm_dma_pkg::*;
#(
    parameter int LEN_W     = 32,
    parameter int MAX_BURST = 16,
    parameter int BC_W      = f_bc_width(MAX_BURST)
) (
    input  logic [LEN_W-1:0]             remaining_i,
    input  logic [$clog2(MAX_BURST)-1:0] offset_i,
    output logic [BC_W-1:0]              burstcount_o
);

    // Compare in a width wide enough for either operand so no bits are lost
    localparam int CMP_W = (LEN_W > BC_W) ? LEN_W : BC_W;

    logic [BC_W-1:0]  w_dist;
    logic [CMP_W-1:0] w_rem_ext;
    logic [CMP_W-1:0] w_dist_ext;

    // Words left before the aligned boundary: always in 1..MAX_BURST
    assign w_dist       = BC_W'(MAX_BURST) - BC_W'(offset_i);
    assign w_rem_ext    = CMP_W'(remaining_i);
    assign w_dist_ext   = CMP_W'(w_dist);
    assign burstcount_o = (w_rem_ext < w_dist_ext) ? BC_W'(w_rem_ext) : w_dist;

endmodule
`default_nettype wire

// File: rtl/avmm_burst_writer.sv
`default_nettype none
// ============================================================================
// Module      : avmm_burst_writer
// Description : DMA write-side drain stage. Accepts a (address, length)
//               command, pulls words from an AXI-Stream source and emits
//               Avalon-MM burst writes that never exceed MAX_BURST beats and
//               never cross a MAX_BURST-word aligned boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module avmm_burst_writer
    import avmm_dma_pkg::*;
#(
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int LEN_W     = 32,
    parameter int MAX_BURST = 16
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [AW-1:0]                    cmd_addr,
    input  logic [LEN_W-1:0]                 cmd_len,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [DW-1:0]                    s_tdata,
    input  logic                             s_tvalid,
    output logic                             s_tready,
    output logic [AW-1:0]                    avm_address,
    output logic                             avm_write,
    output logic [DW-1:0]                    avm_writedata,
    output logic [DW/8-1:0]                  avm_byteenable,
    output logic [f_bc_width(MAX_BURST)-1:0] avm_burstcount,
    input  logic                             avm_waitrequest,
    output logic                             busy,
    output logic                             done
);

    localparam int WS    = f_word_shift(DW);
    localparam int WAW   = AW - WS;
    localparam int BC_W  = f_bc_width(MAX_BURST);
    localparam int OFF_W = $clog2(MAX_BURST);

    state_e           state_q, state_d;
    logic [WAW-1:0]   word_addr_q, word_addr_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [BC_W-1:0]  beat_q, beat_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [BC_W-1:0]  bc_q, bc_d;

    logic [BC_W-1:0]  w_bc_calc;
    logic [WAW-1:0]   w_cmd_word;
    logic             w_accept;

    // Low byte-lane bits of the command address are dropped here
    assign w_cmd_word = WAW'(cmd_addr >> WS);

    avmm_burst_sizer #(
        .LEN_W     (LEN_W),
        .MAX_BURST (MAX_BURST),
        .BC_W      (BC_W)
    ) u_sizer (
        .remaining_i  (rem_q),
        .offset_i     (word_addr_q[OFF_W-1:0]),
        .burstcount_o (w_bc_calc)
    );

    // State and datapath registers; reset abandons any burst in flight
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            word_addr_q <= '0;
            rem_q       <= '0;
            beat_q      <= '0;
            addr_q      <= '0;
            bc_q        <= '0;
        end else begin
            state_q     <= state_d;
            word_addr_q <= word_addr_d;
            rem_q       <= rem_d;
            beat_q      <= beat_d;
            addr_q      <= addr_d;
            bc_q        <= bc_d;
        end
    end

    // Next-state, counter updates and handshake outputs
    always_comb begin
        state_d     = state_q;
        word_addr_d = word_addr_q;
        rem_d       = rem_q;
        beat_d      = beat_q;
        addr_d      = addr_q;
        bc_d        = bc_q;
        cmd_ready   = 1'b0;
        s_tready    = 1'b0;
        avm_write   = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        w_accept    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy      = 1'b0;
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    word_addr_d = w_cmd_word;
                    rem_d       = cmd_len;
                    state_d     = (cmd_len == '0) ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                // Burst parameters are frozen here and held for the burst
                addr_d  = AW'(word_addr_q) << WS;
                bc_d    = w_bc_calc;
                beat_d  = '0;
                state_d = ST_DATA;
            end
            ST_DATA: begin
                avm_write = s_tvalid;
                s_tready  = !avm_waitrequest;
                w_accept  = s_tvalid && !avm_waitrequest;
                if (w_accept) begin
                    if (beat_q == bc_q - BC_W'(1)) begin
                        rem_d       = rem_q - LEN_W'(bc_q);
                        word_addr_d = word_addr_q + WAW'(bc_q);
                        beat_d      = '0;
                        state_d     = (rem_q == LEN_W'(bc_q)) ? ST_DONE : ST_CALC;
                    end else begin
                        beat_d = beat_q + BC_W'(1);
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign avm_address    = addr_q;
    assign avm_burstcount = bc_q;
    assign avm_writedata  = s_tdata;
    assign avm_byteenable = '1;

endmodule
`default_nettype wire

// File: tb/tb_avmm_burst_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_avmm_burst_writer
// Description : Self-checking bench for avmm_burst_writer. A reference model
//               splits each command into aligned bursts and predicts every
//               beat (address, burstcount, data) plus done timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avmm_burst_writer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_len;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [4:0]  avm_burstcount;
    logic        avm_waitrequest;
    logic        busy;
    logic        done;

    avmm_burst_writer #(
        .DW(32), .AW(32), .LEN_W(32), .MAX_BURST(16)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_byteenable(avm_byteenable), .avm_burstcount(avm_burstcount),
        .avm_waitrequest(avm_waitrequest), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [4:0]  bc;
        logic [31:0] data;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] src[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_n = 0;
    int acc_cnt = 0, acc_cyc = 0;
    int done_cnt = 0, done_cyc = 0;
    int beat_total = 0, last_acc_cyc = 0;
    int valid_pct = 100, wait_pct = 0;

    logic        rst_nxt = 1'b0;
    logic        cv_nxt  = 1'b0;
    logic [31:0] ca_nxt  = '0;
    logic [31:0] cl_nxt  = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: split a command into aligned bursts, queue data and beats
    task automatic model(input logic [31:0] a, input logic [31:0] len, output int nb);
        logic [29:0] wa;
        int          rem;
        int          bc;
        logic [31:0] d;
        wa  = a[31:2];
        rem = int'(len);
        nb  = 0;
        while (rem > 0) begin
            bc = 16 - int'(wa % 30'd16);
            if (rem < bc) bc = rem;
            for (int i = 0; i < bc; i++) begin
                d = $urandom;
                src.push_back(d);
                exp_q.push_back('{addr: {wa, 2'b00}, bc: 5'(bc), data: d});
            end
            wa  = wa + 30'(bc);
            rem = rem - bc;
            nb++;
        end
    endtask

    // Outputs are sampled at the negedge: they equal what the next posedge sees
    task automatic observe();
        beat_t e;
        if (avm_write) begin
            chk("wdata_passthru", avm_writedata, s_tdata);
            chk("byteenable", avm_byteenable, 4'hF);
            chk("tready_vs_wait", s_tready, !avm_waitrequest);
        end
        if (!busy) begin
            chk("idle_tready", s_tready, 1'b0);
            chk("idle_write", avm_write, 1'b0);
        end
        if (s_tvalid && s_tready) begin
            chk("stream_pop_is_write", avm_write, 1'b1);
            if (src.size() > 0) void'(src.pop_front());
        end
        if (avm_write && !avm_waitrequest) begin
            chk("beat_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("beat_addr", avm_address, e.addr);
                chk("beat_bc", avm_burstcount, e.bc);
                chk("beat_data", avm_writedata, e.data);
            end
            beat_total++;
            last_acc_cyc = cyc_n;
        end
        if (cmd_valid && cmd_ready) begin
            acc_cnt++;
            acc_cyc = cyc_n;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc_n;
        end
        chk("ready_vs_busy", cmd_ready, !busy);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_n++;
        reset_n   = rst_nxt;
        cmd_valid = cv_nxt;
        cmd_addr  = ca_nxt;
        cmd_len   = cl_nxt;
        s_tvalid  = (src.size() > 0) && (int'($urandom_range(99)) < valid_pct);
        s_tdata   = (src.size() > 0) ? src[0] : $urandom;
        avm_waitrequest = (int'($urandom_range(99)) < wait_pct);
        @(negedge clk);
        observe();
    endtask

    task automatic run_cmd(input logic [31:0] a, input logic [31:0] l,
                           input int vp, input int wp, input bit full);
        int nb, n, acc0, d0;
        model(a, l, nb);
        valid_pct = vp;
        wait_pct  = wp;
        n = 0;
        while (!cmd_ready && n < 200) begin cyc(); n++; end
        ca_nxt = a; cl_nxt = l; cv_nxt = 1'b1;
        acc0 = acc_cnt;
        d0   = done_cnt;
        n = 0;
        while (acc_cnt == acc0 && n < 200) begin cyc(); n++; end
        cv_nxt = 1'b0;
        chk("accept_seen", acc_cnt, acc0 + 1);
        n = 0;
        while (done_cnt == d0 && n < 5000) begin cyc(); n++; end
        chk("done_seen", done_cnt, d0 + 1);
        if (l != 0) chk("done_after_last_beat", done_cyc, last_acc_cyc + 1);
        else        chk("zero_len_done_t1", done_cyc, acc_cyc + 1);
        if (full) chk("throughput_cycles", done_cyc, acc_cyc + int'(l) + nb + 1);
        chk("beats_all_written", exp_q.size(), 0);
        chk("stream_drained", src.size(), 0);
        cyc();
        chk("idle_after_done", cmd_ready, 1'b1);
        chk("done_one_cycle", done, 1'b0);
    endtask

    initial begin
        int n, acc0, d0, nb1, nb2, b0;
        logic [31:0] ra, rl;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
        s_tvalid = 1'b0; s_tdata = '0; avm_waitrequest = 1'b0;

        // Reset state
        rst_nxt = 1'b0;
        repeat (3) cyc();
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_write", avm_write, 1'b0);
        chk("rst_tready", s_tready, 1'b0);
        chk("rst_addr", avm_address, 32'h0);
        chk("rst_bc", avm_burstcount, 5'h0);
        rst_nxt = 1'b1;
        cyc();

        // Single aligned full burst, then boundary split, then zero length
        run_cmd(32'h0000_1000, 32'd16, 100, 0, 1'b1);
        run_cmd(32'h0000_1038, 32'd20, 100, 0, 1'b1);
        run_cmd(32'h0000_1000, 32'd0,  100, 0, 1'b1);

        // Stalls from both sides
        run_cmd(32'h0000_1004, 32'd16, 60, 40, 1'b0);
        for (int i = 0; i < 8; i++) begin
            ra = $urandom & 32'h0000_FFFF;
            rl = $urandom_range(40, 1);
            run_cmd(ra, rl, 50 + 5 * i, 10 + 5 * i, 1'b0);
        end

        // Word-address wrap at the top of memory
        run_cmd(32'hFFFF_FFF8, 32'd6, 100, 0, 1'b1);

        // Reset in the middle of a burst
        model(32'h0000_3000, 32'd16, nb1);
        valid_pct = 100; wait_pct = 0;
        ca_nxt = 32'h0000_3000; cl_nxt = 32'd16; cv_nxt = 1'b1;
        acc0 = acc_cnt;
        n = 0;
        while (acc_cnt == acc0 && n < 200) begin cyc(); n++; end
        cv_nxt = 1'b0;
        b0 = beat_total;
        n = 0;
        while (beat_total - b0 < 5 && n < 200) begin cyc(); n++; end
        chk("mid_reset_beats", beat_total - b0, 5);
        exp_q.delete();
        src.delete();
        d0 = done_cnt;
        rst_nxt = 1'b0; valid_pct = 0;
        cyc();
        rst_nxt = 1'b1;
        cyc();
        chk("mid_reset_write", avm_write, 1'b0);
        chk("mid_reset_busy", busy, 1'b0);
        chk("mid_reset_ready", cmd_ready, 1'b1);
        chk("mid_reset_no_done", done_cnt, d0);
        run_cmd(32'h0000_2000, 32'd4, 100, 0, 1'b1);

        // cmd_valid held high: the second command waits for the first done
        model(32'h0000_1100, 32'd16, nb1);
        model(32'h0000_1200, 32'd8, nb2);
        valid_pct = 100; wait_pct = 0;
        ca_nxt = 32'h0000_1100; cl_nxt = 32'd16; cv_nxt = 1'b1;
        acc0 = acc_cnt;
        d0   = done_cnt;
        n = 0;
        while (acc_cnt == acc0 && n < 200) begin cyc(); n++; end
        ca_nxt = 32'h0000_1200; cl_nxt = 32'd8;
        n = 0;
        while (acc_cnt == acc0 + 1 && n < 500) begin cyc(); n++; end
        cv_nxt = 1'b0;
        chk("b2b_second_accept", acc_cnt, acc0 + 2);
        chk("b2b_first_done", done_cnt, d0 + 1);
        chk("b2b_accept_after_done", acc_cyc, done_cyc + 1);
        n = 0;
        while (done_cnt == d0 + 1 && n < 500) begin cyc(); n++; end
        chk("b2b_second_done", done_cnt, d0 + 2);
        chk("b2b_beats_all", exp_q.size(), 0);
        chk("b2b_stream_drained", src.size(), 0);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc_n);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/avmm_burst_writer.md
# avmm_burst_writer

DMA write-side drain stage. It sits directly downstream of the stream FIFO: it accepts a write command (start address and length in words), pulls words from the FIFO's AXI-Stream master side, and emits Avalon-MM burst writes to memory. Bursts never exceed MAX_BURST beats and never cross a MAX_BURST-word aligned boundary.

## Interface
- DW, 32, data width in bits; a multiple of 8.
- AW, 32, Avalon byte-address width.
- LEN_W, 32, width of the command length field, counted in words.
- MAX_BURST, 16, maximum beats per burst; a power of two, at least 2.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- cmd_addr  in  AW  start byte address; low $clog2(DW/8) bits are ignored (forced 0).
- cmd_len  in  LEN_W  transfer length in words.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- s_tdata  in  DW  stream data from the FIFO.
- s_tvalid  in  1  stream valid.
- s_tready  out  1  stream ready.
- avm_address  out  AW  byte address of the first beat of the current burst.
- avm_write  out  1  write strobe.
- avm_writedata  out  DW  equals s_tdata.
- avm_byteenable  out  DW/8  all ones.
- avm_burstcount  out  $clog2(MAX_BURST)+1  beats in the current burst.
- avm_waitrequest  in  1  slave stall.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a command completes.

## Operation
- FSM states: IDLE, CALC, DATA, DONE.
- IDLE -> CALC on cmd_valid && cmd_ready with cmd_len != 0. Latch the address as a word address and the length into a remaining-words counter.
- IDLE -> DONE on an accepted command with cmd_len == 0. No write is issued.
- CALC (one cycle): compute burstcount = min(remaining, MAX_BURST - (word_addr mod MAX_BURST)).
  - Register avm_address and avm_burstcount; clear the beat counter. Next state is DATA.
- DATA:
  - avm_write = s_tvalid.
  - s_tready = !avm_waitrequest.
  - A beat is accepted when avm_write && !avm_waitrequest.
  - avm_address and avm_burstcount are held stable for the whole burst.
  - avm_write drops whenever s_tvalid is low, and the burst resumes when it returns.
- On the last beat of a burst:
  - remaining -= burstcount; word_addr += burstcount, modulo 2^(AW - log2(DW/8)).
  - If remaining is now 0, go to DONE; otherwise go to CALC.
- DONE: assert done for one cycle, then go to IDLE.
- Outside DATA, s_tready = 0 and avm_write = 0.
- cmd_valid while busy is ignored. The command is not consumed until the FSM returns to IDLE.
- Reset mid-operation: return to IDLE on the next edge and drop avm_write. No done pulse. The partial burst is abandoned.

## Timing
- Reset values (after the first edge with reset_n low):
  - state IDLE; avm_write, s_tready, busy and done at 0; cmd_ready at 1.
  - avm_address, avm_burstcount and all counters at 0.
- Command accepted in cycle T: CALC at T+1, first beat can be presented at T+2.
- One CALC bubble cycle between consecutive bursts.
- done is asserted in the cycle after the final beat is accepted. IDLE (cmd_ready = 1) follows one cycle later.
- cmd_len == 0: done asserts at T+1.
- Peak throughput is MAX_BURST beats per MAX_BURST+1 cycles when s_tvalid is always high and avm_waitrequest is always low.

## Structure
- Package avmm_dma_pkg holds:
  - the state enum;
  - localparam BYTES_PER_WORD = DW/8 and the word-shift width;
  - a function computing the burstcount width from MAX_BURST.
- Sub-module avmm_burst_sizer (combinational) implements the min(remaining, boundary distance) calculation. It is instantiated once and feeds CALC.
- The rest lives in one module: FSM, address, remaining and beat counters.

## Test plan
In all cases DW = 32 and MAX_BURST = 16.
1. cmd_addr 0x1000, cmd_len 16; s_tvalid always 1, waitrequest 0 -> one burst at 0x1000 with burstcount 16 and 16 back-to-back beats; done one cycle after the last beat.
2. cmd_addr 0x1038, cmd_len 20 -> three bursts: (0x1038, 2), (0x1040, 16), (0x1080, 2); 20 beats total with data order preserved.
3. cmd_len 0 -> avm_write never asserts; done at T+1; cmd_ready at T+2.
4. waitrequest high on beats 3–5 and s_tvalid low for 2 cycles mid-burst -> address and burstcount stable; each word written exactly once; no beat accepted while waitrequest is high.
5. reset_n low for one cycle after 5 of 16 beats -> next cycle avm_write = 0 and busy = 0, no done. A following command (0x2000, 4) completes normally.
6. cmd_valid held high during a 16-word transfer with a second command -> the second command is accepted only in IDLE, after the first done pulse.
